// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
// Ramps four 8-bit PWM duty registers toward programmed targets. A shared
// prescaler produces fade ticks, each channel has its own interval counter
// that raises a pending request, and a two-state round-robin engine applies
// one clamped step per update.
module pwm_fade_sequencer #(
  parameter int PRESCALE = 256,
  parameter int NUM_CH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_ch,
  input  logic [7:0] cfg_target,
  input  logic [7:0] cfg_step,
  input  logic [7:0] cfg_interval,
  input  logic       cfg_immediate,
  output logic [7:0] duty_0,
  output logic [7:0] duty_1,
  output logic [7:0] duty_2,
  output logic [7:0] duty_3,
  output logic [3:0] busy,
  output logic [3:0] done_pulse
);

  localparam int            PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_sel;
  logic [1:0]          r_rr_ptr;
  logic [1:0]          w_pick;
  logic                w_found;
  logic [PW-1:0]       r_presc;
  logic                w_tick;
  logic [NUM_CH-1:0]   w_pending;

  assign w_tick = (r_presc == PRESC_LAST);

  // Fade-tick prescaler: counts 0..PRESCALE-1 and wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Per-channel fade state: duty, settings, interval counter, pending, pulse
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [7:0] r_duty;
    logic [7:0] r_target;
    logic [7:0] r_step;
    logic [7:0] r_interval;
    logic [7:0] r_cnt;
    logic       r_pending;
    logic       r_hit;
    logic       r_done;
    logic       w_acc;
    logic       w_upd;
    logic       w_busy;
    logic       w_jump;
    logic       w_hit;
    logic       w_pend_next;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_stepped;
    logic [7:0] w_duty_next;
    logic [7:0] w_target_next;

    assign w_acc  = cfg_valid && cfg_ready && (cfg_ch == 2'(gi));
    assign w_upd  = (r_state == S_UPDATE) && (r_sel == 2'(gi));
    assign w_busy = (r_duty != r_target);
    assign w_jump = cfg_immediate || (cfg_step == 8'd0);
    assign w_sum  = {1'b0, r_duty} + {1'b0, r_step};
    assign w_diff = {1'b0, r_duty} - {1'b0, r_step};

    // One step toward the target, clamped so it never passes it or wraps
    always_comb begin
      w_stepped = r_duty;
      if (r_duty < r_target) begin
        if (w_sum > {1'b0, r_target}) w_stepped = r_target;
        else                          w_stepped = w_sum[7:0];
      end else if (r_duty > r_target) begin
        if (w_diff[8] || (w_diff[7:0] < r_target)) w_stepped = r_target;
        else                                       w_stepped = w_diff[7:0];
      end
    end

    // Next duty/target/pending: a config write wins over tick and update
    always_comb begin
      w_duty_next   = r_duty;
      w_target_next = r_target;
      w_pend_next   = r_pending & ~w_upd;
      // A tick that lands on the update edge still re-arms the request
      if (w_tick && (r_cnt >= r_interval)) w_pend_next = w_pend_next | w_busy;
      if (w_acc) begin
        w_target_next = cfg_target;
        w_pend_next   = 1'b0;
        if (w_jump) w_duty_next = cfg_target;
      end else if (w_upd) begin
        w_duty_next = w_stepped;
      end
    end

    // Only a real duty change that lands on the target counts as completion
    assign w_hit = (w_duty_next != r_duty) && (w_duty_next == w_target_next);

    // Channel registers; done is the completion flag delayed by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_duty     <= '0;
        r_target   <= '0;
        r_step     <= '0;
        r_interval <= '0;
        r_cnt      <= '0;
        r_pending  <= 1'b0;
        r_hit      <= 1'b0;
        r_done     <= 1'b0;
      end else begin
        r_duty    <= w_duty_next;
        r_target  <= w_target_next;
        r_pending <= w_pend_next;
        r_hit     <= w_hit;
        r_done    <= r_hit;
        if (w_acc) begin
          r_step     <= cfg_step;
          r_interval <= cfg_interval;
          r_cnt      <= '0;
        end else if (w_tick) begin
          if (r_cnt >= r_interval) r_cnt <= '0;
          else                     r_cnt <= r_cnt + 8'd1;
        end
      end
    end

    assign w_pending[gi]  = r_pending;
    assign busy[gi]       = w_busy;
    assign done_pulse[gi] = r_done;
  end

  assign duty_0 = g_ch[0].r_duty;
  assign duty_1 = g_ch[1].r_duty;
  assign duty_2 = g_ch[2].r_duty;
  assign duty_3 = g_ch[3].r_duty;

  // Round-robin search: first pending channel at or above rr_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found && w_pending[r_rr_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_pick  = r_rr_ptr + 2'(k);
      end
    end
  end

  // FSM state register, with the selected channel and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && w_found) r_sel <= w_pick;
      if (r_state == S_UPDATE) r_rr_ptr <= r_sel + 2'd1;
    end
  end

  // FSM next state: IDLE picks a channel, UPDATE lasts exactly one cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_next = S_UPDATE;
      S_UPDATE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: block config only for the channel being updated right now
  always_comb begin
    cfg_ready = 1'b1;
    if ((r_state == S_UPDATE) && (cfg_ch == r_sel)) cfg_ready = 1'b0;
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Testbench for pwm_fade_sequencer: directed config writes, an abstract
// per-channel model compared every cycle, and hand-computed literal checks.
module tb_pwm_fade_sequencer;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_target = 8'd0;
  logic [7:0] cfg_step = 8'd0;
  logic [7:0] cfg_interval = 8'd0;
  logic       cfg_immediate = 1'b0;
  logic [7:0] duty_0, duty_1, duty_2, duty_3;
  logic [3:0] busy, done_pulse;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  pwm_fade_sequencer #(.PRESCALE(P), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_target(cfg_target), .cfg_step(cfg_step), .cfg_interval(cfg_interval),
    .cfg_immediate(cfg_immediate),
    .duty_0(duty_0), .duty_1(duty_1), .duty_2(duty_2), .duty_3(duty_3),
    .busy(busy), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_duty[4], m_tgt[4], m_stp[4], m_int[4], m_cnt[4];
  bit m_pend[4], m_hit[4], m_done[4];
  bit m_upd;
  int m_sel, m_rr, m_presc;

  function automatic int approach(input int d, input int t, input int s);
    if (d < t) return (d + s > t) ? t : d + s;
    if (d > t) return (d - s < t) ? t : d - s;
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_duty[i] = 0; m_tgt[i] = 0; m_stp[i] = 0; m_int[i] = 0; m_cnt[i] = 0;
      m_pend[i] = 0; m_hit[i] = 0; m_done[i] = 0;
    end
    m_upd = 0; m_sel = 0; m_rr = 0; m_presc = 0;
  endtask

  task automatic model_edge();
    int nd[4], nt[4];
    bit np[4];
    bit tick, acc, found;
    int ch, c;
    tick = (m_presc == P - 1);
    ch   = int'(cfg_ch);
    acc  = cfg_valid && !(m_upd && ch == m_sel);
    for (int i = 0; i < 4; i++) begin
      nd[i] = m_duty[i]; nt[i] = m_tgt[i]; np[i] = m_pend[i];
    end
    if (m_upd) begin
      nd[m_sel] = approach(m_duty[m_sel], m_tgt[m_sel], m_stp[m_sel]);
      np[m_sel] = 0;
    end
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (m_cnt[i] >= m_int[i]) begin
          m_cnt[i] = 0;
          if (m_duty[i] != m_tgt[i]) np[i] = 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    if (acc) begin
      nt[ch] = int'(cfg_target);
      m_stp[ch] = int'(cfg_step);
      m_int[ch] = int'(cfg_interval);
      m_cnt[ch] = 0;
      np[ch] = 0;
      if (cfg_immediate || cfg_step == 0) nd[ch] = int'(cfg_target);
    end
    if (m_upd) begin
      m_upd = 0;
      m_rr = (m_sel + 1) % 4;
    end else begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_rr + k) % 4;
        if (!found && m_pend[c]) begin
          found = 1; m_sel = c;
        end
      end
      m_upd = found;
    end
    for (int i = 0; i < 4; i++) begin
      m_done[i] = m_hit[i];
      m_hit[i]  = (nd[i] != m_duty[i]) && (nd[i] == nt[i]);
      m_duty[i] = nd[i]; m_tgt[i] = nt[i]; m_pend[i] = np[i];
    end
    m_presc = tick ? 0 : m_presc + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // Compare DUT outputs against the model on every falling edge
  initial begin
    logic [3:0] eb, ed;
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        for (int i = 0; i < 4; i++) begin
          eb[i] = (m_duty[i] != m_tgt[i]);
          ed[i] = m_done[i];
        end
        chk("model_duty_0", int'(duty_0), m_duty[0]);
        chk("model_duty_1", int'(duty_1), m_duty[1]);
        chk("model_duty_2", int'(duty_2), m_duty[2]);
        chk("model_duty_3", int'(duty_3), m_duty[3]);
        chk("model_busy", int'(busy), int'(eb));
        chk("model_done_pulse", int'(done_pulse), int'(ed));
        chk("model_cfg_ready", int'(cfg_ready), (m_upd && int'(cfg_ch) == m_sel) ? 0 : 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cfg_write(input int ch, input int tgt, input int stp, input int itv, input int imm);
    int n;
    bit rdy;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_target = 8'(tgt);
    cfg_step = 8'(stp); cfg_interval = 8'(itv); cfg_immediate = imm[0];
    n = 0;
    do begin
      @(negedge clk); rdy = cfg_ready;
      @(posedge clk); n++;
    end while (!rdy && n < 50);
    #1 cfg_valid = 1'b0; cfg_immediate = 1'b0;
    chk("cfg_accept", int'(rdy), 1);
    $display("cfg write ch%0d target=0x%02h step=%0d interval=%0d imm=%0d accepted after %0d cycle(s)",
             ch, tgt, stp, itv, imm, n);
  endtask

  initial begin
    int q[$];
    int last, pulses, n, viol, prev_ch;
    bit found;
    logic [7:0] snap[4], now_d[4];

    #23 rst_n = 1'b1;
    #1;
    chk("reset_duty_0", int'(duty_0), 0);
    chk("reset_duty_3", int'(duty_3), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cfg_ready", int'(cfg_ready), 1);
    cmp_en = 1'b1;

    // Idle after reset: nothing moves, no pulses
    pulses = 0;
    repeat (1000) begin
      @(negedge clk);
      if (done_pulse != 4'd0 || busy != 4'd0) pulses++;
    end
    chk("idle_quiet_cycles", pulses, 0);

    // ch0 ramp 0 -> 10 in steps of 3
    cfg_write(0, 10, 3, 0, 0);
    q.delete(); last = 0; pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (int'(duty_0) != last) begin last = int'(duty_0); q.push_back(last); end
      if (done_pulse[0]) pulses++;
    end
    chk("ramp0_len", q.size(), 4);
    if (q.size() == 4) begin
      chk("ramp0_v0", q[0], 3); chk("ramp0_v1", q[1], 6);
      chk("ramp0_v2", q[2], 9); chk("ramp0_v3", q[3], 10);
    end
    chk("ramp0_done_count", pulses, 1);
    chk("ramp0_busy_low", int'(busy[0]), 0);

    // Target equal to current duty: stays idle, no pulse
    cfg_write(1, 0, 5, 0, 0);
    pulses = 0;
    repeat (20) begin @(negedge clk); if (done_pulse[1] || busy[1]) pulses++; end
    chk("same_target_quiet", pulses, 0);

    // ch2: jump to 0xF0, climb to 0xFF without wrap, then descend to 0x05
    cfg_write(2, 'hF0, 0, 0, 0);
    @(negedge clk);
    chk("ch2_jump_F0", int'(duty_2), 'hF0);
    cfg_write(2, 'hFF, 'h80, 0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (busy[2] && n < 100);
    chk("ch2_top_FF", int'(duty_2), 'hFF);
    cfg_write(2, 'h05, 'h10, 0, 0);
    q.delete(); last = 'hFF; n = 0;
    do begin
      @(negedge clk); n++;
      if (int'(duty_2) != last) begin last = int'(duty_2); q.push_back(last); end
    end while (busy[2] && n < 400);
    chk("ch2_desc_len", q.size(), 16);
    if (q.size() >= 2) begin
      chk("ch2_desc_prev", q[q.size()-2], 'h0F);
      chk("ch2_desc_final", q[q.size()-1], 'h05);
    end

    // All four channels fading with interval 0: strict round-robin service
    cfg_write(0, 200, 1, 0, 0);
    cfg_write(1, 200, 1, 0, 0);
    cfg_write(2, 200, 1, 0, 0);
    cfg_write(3, 200, 1, 0, 0);
    repeat (10) @(negedge clk);
    snap[0] = duty_0; snap[1] = duty_1; snap[2] = duty_2; snap[3] = duty_3;
    n = 0; viol = 0; prev_ch = -1;
    repeat (80) begin
      @(negedge clk);
      now_d[0] = duty_0; now_d[1] = duty_1; now_d[2] = duty_2; now_d[3] = duty_3;
      for (int i = 0; i < 4; i++) begin
        if (now_d[i] != snap[i]) begin
          if (prev_ch >= 0 && i != (prev_ch + 1) % 4) viol++;
          prev_ch = i; n++;
        end
        snap[i] = now_d[i];
      end
    end
    chk("rr_order_violations", viol, 0);
    chk("rr_update_count", n, 40);

    // Immediate jump on ch1 mid-fade, pulse one cycle after it lands
    cfg_write(1, 'h40, 4, 0, 1);
    @(negedge clk);
    chk("imm_duty_1", int'(duty_1), 'h40);
    chk("imm_done_early", int'(done_pulse[1]), 0);
    @(negedge clk);
    chk("imm_done_pulse", int'(done_pulse[1]), 1);

    // Write to ch3 while ch3 is being updated: held off one cycle
    @(posedge clk); #1 cfg_ch = 2'd3;
    found = 1'b0; n = 0;
    while (!found && n < 40) begin
      @(negedge clk); n++;
      if (!cfg_ready) found = 1'b1;
    end
    chk("ch3_blocked_seen", int'(found), 1);
    cfg_valid = 1'b1; cfg_target = 8'h22; cfg_step = 8'd1; cfg_interval = 8'd0; cfg_immediate = 1'b1;
    @(negedge clk);
    chk("ch3_ready_after", int'(cfg_ready), 1);
    chk("ch3_not_yet", int'(duty_3 == 8'h22), 0);
    @(posedge clk); #1 cfg_valid = 1'b0; cfg_immediate = 1'b0;
    @(negedge clk);
    chk("ch3_jump_22", int'(duty_3), 'h22);
    $display("cfg write ch3 target=0x22 imm=1 held during update, accepted next cycle");

    // Reset in the middle of a fade on ch0
    cfg_write(0, 'h30, 0, 0, 0);
    cfg_write(0, 'h80, 1, 0, 0);
    found = 1'b0; n = 0;
    while (!found && n < 200) begin
      @(negedge clk); n++;
      if (duty_0 == 8'h33) found = 1'b1;
    end
    chk("fade_reached_33", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_duty_0", int'(duty_0), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(cfg_ready), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    repeat (200) begin
      @(negedge clk);
      if (duty_0 != 8'd0 || busy != 4'd0 || done_pulse != 4'd0) pulses++;
    end
    chk("post_reset_idle", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
- Ramps the four PWM duty-cycle registers (gen0 ch0/ch1, gen1 ch0/ch1) smoothly from their current value to a programmed target.
- Sits between the SPI register bank and the PWM peripheral. Its duty outputs drive the peripheral's duty-cycle inputs directly.
- Per-channel settings are target, step size and step interval. A single round-robin update engine services all channels, one update at a time.

Parameters:
- PRESCALE, 256, clk cycles per fade tick; legal range 2..65536.
- NUM_CH, 4, number of duty channels; fixed at 4, index width 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write can be accepted this cycle
- cfg_ch  in  2  channel index: 0=gen0ch0, 1=gen0ch1, 2=gen1ch0, 3=gen1ch1
- cfg_target  in  8  target duty
- cfg_step  in  8  duty increment per update; 0 means jump
- cfg_interval  in  8  fade ticks between updates, minus 1
- cfg_immediate  in  1  jump straight to target
- duty_0, duty_1, duty_2, duty_3  out  8 each  current duty per channel
- busy  out  4  channel still fading (duty != target)
- done_pulse  out  4  one-cycle pulse when a channel reaches its target

Behaviour:
- Reset (async, active-low): the following all go to 0: every duty, target, step, interval, interval counter, pending flag, prescaler, rr_ptr, busy and done_pulse. FSM goes to IDLE. cfg_ready goes to 1.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = 1 for exactly one cycle when count == PRESCALE-1.
- Per-channel interval counter (on tick):
  - If cnt >= interval: cnt <= 0, and pending <= pending | busy.
  - Otherwise cnt <= cnt + 1.
  - interval = 0 therefore yields one update per tick.
  - A pending flag that is already set stays set; extra steps are dropped, not queued.
- FSM has two states:
  - IDLE: if any pending bit is set, sel <= first pending channel searching upward from rr_ptr (mod 4), then go to UPDATE. Otherwise stay in IDLE.
  - UPDATE (one cycle): apply a step to channel sel, clear pending[sel], set rr_ptr <= sel+1 (mod 4), return to IDLE.
  - Each update therefore costs 2 cycles. All 4 channels are serviced within 8 cycles.
- Step arithmetic uses 9-bit intermediate values. Overshoot is not permitted.
  - duty < target: duty <= min(duty + step, target).
  - duty > target: duty <= max(duty - step, target), with no underflow below 0.
  - 8'hFF is reachable; no wrap to 0.
- busy[i] = (duty_i != target_i), combinational from registers.
- done_pulse[i] asserts one cycle after the cycle in which duty_i becomes equal to target_i. This applies whether it came from an update or a jump.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready.
  - cfg_ready = 0 only when state == UPDATE && cfg_ch == sel; it is 1 otherwise.
  - On accept: latch target, step and interval for cfg_ch; clear cnt[cfg_ch] and pending[cfg_ch].
  - If cfg_immediate or cfg_step == 0: duty <= target in the same edge.
  - Otherwise the first step occurs after interval+1 ticks.
- Simultaneous events:
  - Config write and tick on the same channel: the config write wins; cnt and pending are cleared.
  - Config write on channel A while UPDATE serves channel B: both take effect.
  - New target written mid-fade: the ramp continues from the current duty toward the new target. No done_pulse is issued for the old target.
  - Writing target == current duty with no step in flight: busy stays 0 and no done_pulse is issued.
- Reset mid-fade: all duties return to 0 immediately (async). The PWM outputs therefore go low.

Test Plan:
- Reset release with no writes -> all duty = 0, busy = 0, cfg_ready = 1, no done_pulse for 1000 cycles.
- PRESCALE=4; write ch0 target=10, step=3, interval=0 -> duty_0 follows 0, 3, 6, 9, 10. One update per tick (every 4 clk, 2-cycle FSM latency). done_pulse[0] fires once, after duty reaches 10. busy[0] falls with it.
- Write ch2 target=0xFF, step=0x80 from duty 0xF0 -> duty_2 = 0xFF (no wrap). Then write target=0x05, step=0x10 -> duty_2 descends to 0x05 exactly with no underflow.
- All 4 channels with interval=0 and PRESCALE=4 -> updates are served in rr order 0, 1, 2, 3. No channel is updated twice before the others. Each channel's pending is cleared within 8 cycles.
- Immediate write ch1 target=0x40 -> duty_1 = 0x40 on the next edge, done_pulse[1] fires one cycle later. A cfg write to ch3 presented during UPDATE of ch3 -> cfg_ready = 0 that cycle, and the write is accepted the next cycle.
- Assert rst_n low mid-fade on ch0 (duty = 0x33) -> duty_0 = 0 asynchronously. After release, the channel stays idle until rewritten.
